// File: rtl/gpr_wb_arbiter_pkg.sv
// gpr_wb_arbiter_pkg: shared widths, limits and FSM encoding for the GPR writeback arbiter
package gpr_wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int MAX_WAIT = 4;
  localparam int WAIT_W = 3;
  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_e;
endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// gpr_wb_arbiter_if: pipeline, long-unit, decode and GPR write-port signals of the arbiter
interface gpr_wb_arbiter_if;
  import gpr_wb_arbiter_pkg::*;
  logic pipe_we;
  logic [AW-1:0] pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic lu_issue;
  logic [AW-1:0] lu_issue_rd;
  logic lu_valid;
  logic [AW-1:0] lu_rd;
  logic [XLEN-1:0] lu_data;
  logic lu_ready;
  logic [AW-1:0] dec_rs1;
  logic [AW-1:0] dec_rs2;
  logic [AW-1:0] dec_rd;
  logic hazard;
  logic stall_req;
  logic gpr_we;
  logic [AW-1:0] gpr_rd;
  logic [XLEN-1:0] gpr_data;
  modport master (
    output pipe_we, pipe_rd, pipe_data, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
           dec_rs1, dec_rs2, dec_rd,
    input  lu_ready, hazard, stall_req, gpr_we, gpr_rd, gpr_data
  );
  modport slave (
    input  pipe_we, pipe_rd, pipe_data, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
           dec_rs1, dec_rs2, dec_rd,
    output lu_ready, hazard, stall_req, gpr_we, gpr_rd, gpr_data
  );
endinterface

// File: rtl/gpr_wb_arbiter_scoreboard.sv
// gpr_scoreboard: busy bits for pending long-op destinations and the decode hazard lookup
module gpr_scoreboard
  import gpr_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic set_en,
  input  logic [AW-1:0] set_idx,
  input  logic clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  output logic hazard
);
  logic [NREG-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
    hazard = !rst && ((rs1 != '0 && busy_q[rs1]) || (rs2 != '0 && busy_q[rs2]) ||
                      (rd != '0 && busy_q[rd]));
  end
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the single GPR write port between pipeline WB and the long-latency unit
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
(
  input logic clk,
  input logic rst,
  gpr_wb_arbiter_if.slave bus
);
  state_e state_q, state_d;
  logic [AW-1:0] hold_rd_q, hold_rd_d;
  logic [XLEN-1:0] hold_data_q, hold_data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic direct, capture, drain, lu_wr, hold_wr;
  always_comb begin
    bus.lu_ready = state_q == ST_IDLE && !rst;
    direct = bus.lu_ready && bus.lu_valid && !bus.pipe_we;
    capture = bus.lu_ready && bus.lu_valid && bus.pipe_we;
    drain = state_q == ST_HOLD && !bus.pipe_we && !rst;
    lu_wr = direct && bus.lu_rd != '0;
    hold_wr = drain && hold_rd_q != '0;
    bus.gpr_we = !rst && (bus.pipe_we || lu_wr || hold_wr);
    bus.gpr_rd = !bus.gpr_we ? '0 : bus.pipe_we ? bus.pipe_rd : lu_wr ? bus.lu_rd : hold_rd_q;
    bus.gpr_data = !bus.gpr_we ? '0 : bus.pipe_we ? bus.pipe_data : lu_wr ? bus.lu_data : hold_data_q;
    bus.stall_req = !rst && state_q == ST_HOLD && wait_q >= WAIT_W'(MAX_WAIT);
    state_d = capture ? ST_HOLD : drain ? ST_IDLE : state_q;
    hold_rd_d = capture ? bus.lu_rd : hold_rd_q;
    hold_data_d = capture ? bus.lu_data : hold_data_q;
    wait_d = capture ? '0 :
             (state_q == ST_HOLD && bus.pipe_we && wait_q != '1) ? wait_q + 1'b1 : wait_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_rd_q <= '0;
      hold_data_q <= '0;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      hold_rd_q <= hold_rd_d;
      hold_data_q <= hold_data_d;
      wait_q <= wait_d;
    end
  end
  gpr_scoreboard u_sb (
    .clk(clk),
    .rst(rst),
    .set_en(bus.lu_issue),
    .set_idx(bus.lu_issue_rd),
    .clr_en(lu_wr || hold_wr),
    .clr_idx(lu_wr ? bus.lu_rd : hold_rd_q),
    .rs1(bus.dec_rs1),
    .rs2(bus.dec_rs2),
    .rd(bus.dec_rd),
    .hazard(bus.hazard)
  );
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_gpr_wb_arbiter;
  typedef struct {logic [4:0] rd; logic [31:0] d;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  res_t held[$];
  int blocked = 0;
  bit [31:0] busy = '0;
  gpr_wb_arbiter_if bus ();
  gpr_wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic we, rdy, hz, st;
    logic [4:0] rd;
    logic [31:0] d;
    we = 0; rd = 0; d = 0; rdy = 0; hz = 0; st = 0;
    if (!rst) begin
      rdy = held.size() == 0;
      if (bus.pipe_we) begin we = 1; rd = bus.pipe_rd; d = bus.pipe_data; end
      else if (rdy && bus.lu_valid && bus.lu_rd != 0) begin we = 1; rd = bus.lu_rd; d = bus.lu_data; end
      else if (!rdy && held[0].rd != 0) begin we = 1; rd = held[0].rd; d = held[0].d; end
      hz = (bus.dec_rs1 != 0 && busy[bus.dec_rs1]) || (bus.dec_rs2 != 0 && busy[bus.dec_rs2]) ||
           (bus.dec_rd != 0 && busy[bus.dec_rd]);
      st = !rdy && blocked >= 4;
    end
    chk("m_gpr_we", bus.gpr_we, we);
    chk("m_gpr_rd", bus.gpr_rd, rd);
    chk("m_gpr_data", bus.gpr_data, d);
    chk("m_lu_ready", bus.lu_ready, rdy);
    chk("m_hazard", bus.hazard, hz);
    chk("m_stall_req", bus.stall_req, st);
  end
  always @(posedge clk) begin
    if (rst) begin
      held.delete();
      blocked = 0;
      busy = '0;
    end else begin
      if (held.size() == 0) begin
        if (bus.lu_valid && bus.pipe_we) begin
          held.push_back('{bus.lu_rd, bus.lu_data});
          blocked = 0;
        end else if (bus.lu_valid) busy[bus.lu_rd] = 0;
      end else if (bus.pipe_we) blocked++;
      else busy[held.pop_front().rd] = 0;
      if (bus.lu_issue) busy[bus.lu_issue_rd] = 1;
      busy[0] = 0;
    end
  end
  task automatic idle_in();
    bus.pipe_we = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
    bus.lu_issue = 0; bus.lu_issue_rd = 0;
    bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_data = 0;
    bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle_in();
    #2;
    chk("rst_gpr_we", bus.gpr_we, 0);
    chk("rst_lu_ready", bus.lu_ready, 0);
    chk("rst_hazard", bus.hazard, 0);
    chk("rst_stall", bus.stall_req, 0);
    tick(); tick();
    rst = 0;
    tick();
    bus.lu_valid = 1; bus.lu_rd = 5; bus.lu_data = 32'hA5;
    #1;
    chk("t1_we", bus.gpr_we, 1);
    chk("t1_rd", bus.gpr_rd, 5);
    chk("t1_data", bus.gpr_data, 32'hA5);
    chk("t1_ready", bus.lu_ready, 1);
    tick();
    bus.lu_rd = 0; bus.lu_data = 32'h33;
    #1;
    chk("t1_x0_we", bus.gpr_we, 0);
    chk("t1_x0_ready", bus.lu_ready, 1);
    tick();
    bus.pipe_we = 1; bus.pipe_rd = 3; bus.pipe_data = 32'h11;
    bus.lu_valid = 1; bus.lu_rd = 7; bus.lu_data = 32'h22;
    #1;
    chk("t2_c0_rd", bus.gpr_rd, 3);
    chk("t2_c0_data", bus.gpr_data, 32'h11);
    tick();
    idle_in();
    #1;
    chk("t2_c1_ready", bus.lu_ready, 0);
    chk("t2_c1_rd", bus.gpr_rd, 7);
    chk("t2_c1_data", bus.gpr_data, 32'h22);
    tick();
    chk("t2_c2_ready", bus.lu_ready, 1);
    chk("t2_c2_we", bus.gpr_we, 0);
    bus.lu_valid = 1; bus.lu_rd = 12; bus.lu_data = 32'hC0FFEE;
    for (int i = 0; i < 6; i++) begin
      bus.pipe_we = 1; bus.pipe_rd = 5'(i + 1); bus.pipe_data = 32'(i + 32'h100);
      #1;
      if (i == 4) chk("t3_stall_lo", bus.stall_req, 0);
      if (i == 5) chk("t3_stall_hi", bus.stall_req, 1);
      tick();
      bus.lu_valid = 0;
    end
    idle_in();
    #1;
    chk("t3_drain_rd", bus.gpr_rd, 12);
    chk("t3_drain_data", bus.gpr_data, 32'hC0FFEE);
    tick();
    chk("t3_after_stall", bus.stall_req, 0);
    bus.lu_issue = 1; bus.lu_issue_rd = 9;
    tick();
    idle_in(); bus.dec_rs2 = 9;
    #1;
    chk("t4_hz_set", bus.hazard, 1);
    tick();
    bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_data = 32'h99;
    #1;
    chk("t4_commit_we", bus.gpr_we, 1);
    chk("t4_hz_commit", bus.hazard, 1);
    tick();
    bus.lu_valid = 0;
    #1;
    chk("t4_hz_clear", bus.hazard, 0);
    bus.lu_issue = 1; bus.lu_issue_rd = 0;
    tick();
    idle_in();
    #1;
    chk("t4_x0_hz", bus.hazard, 0);
    bus.lu_issue = 1; bus.lu_issue_rd = 9;
    tick();
    bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_data = 32'h55;
    tick();
    idle_in(); bus.dec_rs1 = 9;
    #1;
    chk("t5_set_wins", bus.hazard, 1);
    bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_data = 32'h66;
    tick();
    bus.lu_valid = 0;
    #1;
    chk("t5_cleared", bus.hazard, 0);
    idle_in();
    bus.lu_issue = 1; bus.lu_issue_rd = 20;
    tick();
    idle_in();
    bus.pipe_we = 1; bus.pipe_rd = 2; bus.pipe_data = 32'h77;
    bus.lu_valid = 1; bus.lu_rd = 20; bus.lu_data = 32'hDEAD;
    tick();
    idle_in(); bus.dec_rd = 20;
    rst = 1;
    #1;
    chk("t6_rst_we", bus.gpr_we, 0);
    chk("t6_rst_ready", bus.lu_ready, 0);
    chk("t6_rst_hz", bus.hazard, 0);
    tick();
    rst = 0;
    #1;
    chk("t6_post_we", bus.gpr_we, 0);
    chk("t6_post_ready", bus.lu_ready, 1);
    chk("t6_post_hz", bus.hazard, 0);
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
